skid_reg: RTL and testbench
===========================

Name: skid_reg

Overview:
- Parametrised successor to the plain write-enabled flip-flop: an elastic pipeline register with a valid/ready handshake on both sides.
- Holds up to two entries (main + skid), so upstream ready is a registered signal with no combinational path from downstream ready.
- Sits between MIPS pipeline stages (e.g. IF/ID, ID/EX), replacing bare we-gated registers where stall and flush must be decoupled.

Parameters:
- N, 32, data width in bits
- RESET_VAL, {N{1'b0}}, value loaded into main and skid registers on reset
- CNT_W, 16, stall counter width (used only with SKID_STATS_EN)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream presents data
- in_ready  output  1  block can accept data this cycle
- in  input  N  upstream data
- out_valid  output  1  out holds valid data
- out_ready  input  1  downstream accepts data this cycle
- out  output  N  downstream data, driven from the main register
- stall_cnt  output  CNT_W  present only with SKID_STATS_EN

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high, port `reset`.
- Transfer events:
  - accept = in_valid & in_ready
  - send = out_valid & out_ready
- States:
  - EMPTY: out_valid=0, in_ready=1
  - BUSY: main valid; out_valid=1, in_ready=1
  - FULL: main and skid valid; out_valid=1, in_ready=0
- in_ready and out_valid are decoded from the state register only; neither depends combinationally on any input.
- Transitions, evaluated at the rising edge:
  - EMPTY, accept -> BUSY, main<=in
  - BUSY, accept & send -> BUSY, main<=in
  - BUSY, accept & !send -> FULL, skid<=in
  - BUSY, !accept & send -> EMPTY
  - FULL, send -> BUSY, main<=skid (accept impossible since in_ready=0)
  - Any other case: hold all state and data.
- Latency: data accepted in EMPTY appears on out with out_valid=1 the following cycle. Throughput is one transfer per cycle in steady state (BUSY with accept & send).
- Ordering: strict FIFO. An entry in skid always leaves after main.
- Stability: while out_valid=1 and out_ready=0, out and out_valid remain unchanged in the next cycle, unless flush or reset occurs.
- flush: highest synchronous priority.
  - Next state is EMPTY regardless of accept/send.
  - Any data offered in the flush cycle is dropped.
  - main/skid data contents are retained (don't-care); only validity is cleared.
- reset, async, any time including mid-transfer:
  - state=EMPTY, out_valid=0, main=skid=RESET_VAL, so out=RESET_VAL
  - in_ready reads 1 once the state is EMPTY
  - inputs are ignored while reset is high
- Simultaneous reset and flush: reset wins.
- X-safety: in_valid=X is never sampled while reset is high.

Optional Feature:
- Macro: SKID_STATS_EN
- Defined:
  - Port stall_cnt exists.
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at all ones and does not wrap.
  - Cleared to 0 by reset; unaffected by flush.
- Undefined: stall_cnt port and counter logic are absent. CNT_W is ignored. All other behaviour is identical.

Test Plan:
1. Reset check: assert reset for 12 ns mid-cycle with RESET_VAL='h5a -> immediately out='h5a, out_valid=0; after release in_ready=1.
2. Passthrough: out_ready=1, stream in='haa,'hbb,'hcc on consecutive cycles -> out='haa,'hbb,'hcc one cycle later each, out_valid=1 throughout, in_ready never drops.
3. Backpressure/skid: out_ready=0, push 'haa then 'hbb -> state FULL, in_ready=0, out='haa held. Raise out_ready -> 'haa then 'hbb delivered in order, in_ready returns 1 after the first send.
4. Flush while FULL with in_valid=1, in='hcc -> next cycle out_valid=0, in_ready=1. 'hcc is never emitted.
5. Async reset mid-transfer: assert reset between clock edges while in FULL -> out_valid drops before the next edge, out=RESET_VAL; no stale entry appears after release.
6. SKID_STATS_EN: hold out_valid=1, out_ready=0 for 20 cycles with CNT_W=4 -> stall_cnt reaches 15 and stays at 15. Reset -> 0. Flush leaves the count unchanged.

Source files
------------

// File: rtl/skid_reg.sv
// Elastic two-entry pipeline register (main + skid) with valid/ready on both sides; SKID_STATS_EN adds stall_cnt.
// Latency: one cycle from accept to out_valid; one transfer per cycle in steady state.
// Backpressure: in_ready is decoded from the state register only, so it has no combinational path from out_ready.
module skid_reg #(
  parameter int           N         = 32,
  parameter logic [N-1:0] RESET_VAL = {N{1'b0}},
  parameter int           CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out
`ifdef SKID_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   main_q;
  logic [N-1:0]   skid_q;
  logic           accept;
  logic           send;

  if (N < 1 || CNT_W < 1) begin : g_bad_param
    $error("skid_reg: N and CNT_W must be at least 1");
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out       = main_q;
  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;

  // Flush only clears validity; the data registers keep whatever they held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= BUSY;
            main_q <= in;
          end
        end
        BUSY: begin
          if (accept && send) begin
            main_q <= in;
          end else if (accept) begin
            state  <= FULL;
            skid_q <= in;
          end else if (send) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (send) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef SKID_STATS_EN
  // Saturating count of cycles where downstream holds off valid data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Directed bench for skid_reg: reset, passthrough, skid/backpressure, flush, async reset, optional stall counter.
module tb_skid_reg;

  localparam int          N     = 8;
  localparam int          CNT_W = 4;
  localparam logic [N-1:0] RV   = 8'h5a;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
`ifdef SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int ntests = 0;
  int nfail  = 0;

  skid_reg #(.N(N), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b0;

    // 1. async reset mid-cycle, 12 ns wide
    #2 reset = 1'b1;
    #1;
    chk("rst_out", 32'(out), 32'(RV));
    chk("rst_vld", 32'(out_valid), 32'd0);
    #11 reset = 1'b0;
    step();
    chk("rst_rdy", 32'(in_ready), 32'd1);

    // 2. passthrough
    out_ready = 1'b1; in_valid = 1'b1; in = 8'haa;
    step();
    chk("pt_out0", 32'(out), 32'haa);
    chk("pt_vld0", 32'(out_valid), 32'd1);
    chk("pt_rdy0", 32'(in_ready), 32'd1);
    in = 8'hbb;
    step();
    chk("pt_out1", 32'(out), 32'hbb);
    chk("pt_rdy1", 32'(in_ready), 32'd1);
    in = 8'hcc;
    step();
    chk("pt_out2", 32'(out), 32'hcc);
    chk("pt_vld2", 32'(out_valid), 32'd1);
    chk("pt_rdy2", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    chk("pt_drain", 32'(out_valid), 32'd0);

    // 3. backpressure fills skid, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in = 8'haa;
    step();
    chk("bp_busy_rdy", 32'(in_ready), 32'd1);
    in = 8'hbb;
    step();
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    chk("bp_full_out", 32'(out), 32'haa);
    in_valid = 1'b0;
    step();
    chk("bp_hold_out", 32'(out), 32'haa);
    chk("bp_hold_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_send1", 32'(out), 32'hbb);
    chk("bp_rdy_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // 4. flush while FULL with data offered
    out_ready = 1'b0; in_valid = 1'b1; in = 8'h11;
    step();
    in = 8'h22;
    step();
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1; in = 8'hcc;
    step();
    chk("fl_vld", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_cc", 32'(out_valid), 32'd0);

    // 5. async reset while FULL, between edges
    out_ready = 1'b0; in_valid = 1'b1; in = 8'h33;
    step();
    in = 8'h44;
    step();
    chk("ar_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("ar_vld", 32'(out_valid), 32'd0);
    chk("ar_out", 32'(out), 32'(RV));
    chk("ar_rdy", 32'(in_ready), 32'd1);
    #3 reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_no_stale", 32'(out_valid), 32'd0);
    chk("ar_out_after", 32'(out), 32'(RV));

`ifdef SKID_STATS_EN
    // 6. stall counter: counts, survives flush, saturates, clears on reset
    chk("sc_zero", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in = 8'h55;
    step();
    in_valid = 1'b0;
    chk("sc_first", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("sc_five", 32'(stall_cnt), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sc_flush_edge", 32'(stall_cnt), 32'd6);
    step();
    chk("sc_after_flush", 32'(stall_cnt), 32'd6);
    in_valid = 1'b1; in = 8'h66;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sc_sat", 32'(stall_cnt), 32'd15);
    step();
    chk("sc_sat_hold", 32'(stall_cnt), 32'd15);
    #3 reset = 1'b1;
    #1;
    chk("sc_reset", 32'(stall_cnt), 32'd0);
    #3 reset = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
